// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial-evaluator arbiter: FSM states,
// operand widths and the default WAIT timeout.
package poly_pkg;

  localparam int X_W         = 8;
  localparam int C_W         = 16;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/poly_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// (with wrap) from the entry after the last one served.
module rr_picker
  import poly_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_served,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan farthest-first so the nearest requester after last_served overrides.
  always_comb begin
    w_idx       = '0;
    o_winner    = '0;
    o_any_valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last_served) + k) % N_REQ);
      if (i_req[w_idx]) begin
        o_winner    = w_idx;
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/poly_arbiter.sv
// Round-robin arbiter sharing one a*x^2+b*x+c evaluator among N_REQ requesters.
// Define POLY_ARB_TIMEOUT_EN to abort operations stuck in WAIT for TIMEOUT cycles.
module poly_arbiter
  import poly_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [X_W*N_REQ-1:0] i_req_x,
  input  logic [C_W*N_REQ-1:0] i_req_a,
  input  logic [C_W*N_REQ-1:0] i_req_b,
  input  logic [C_W*N_REQ-1:0] i_req_c,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [N_REQ-1:0]     o_done,
  output logic [C_W-1:0]       o_rsp_result,
  output logic                 o_rsp_err,
  output logic                 o_ev_enable,
  output logic [X_W-1:0]       o_ev_x,
  output logic [C_W-1:0]       o_ev_a,
  output logic [C_W-1:0]       o_ev_b,
  output logic [C_W-1:0]       o_ev_c,
  input  logic                 i_ev_ready,
  input  logic                 i_ev_valid,
  input  logic [C_W-1:0]       i_ev_result,
  output logic                 o_ev_reset
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("poly_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("poly_arbiter: TIMEOUT must be at least 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_last;
  logic [X_W-1:0]   r_ev_x;
  logic [C_W-1:0]   r_ev_a;
  logic [C_W-1:0]   r_ev_b;
  logic [C_W-1:0]   r_ev_c;
  logic [C_W-1:0]   r_rsp_result;
  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic             w_grant;
  logic             w_capture;
  logic             w_timeout;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req         (i_req),
    .i_last_served (r_last),
    .o_winner      (w_win),
    .o_any_valid   (w_any)
  );

`ifdef POLY_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;
  logic             r_ev_reset;
`endif

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any && i_ev_ready) begin
          w_grant = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (i_ev_valid) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
`ifdef POLY_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ev_enable = (r_state == S_ISSUE);
    o_done      = '0;
    if (r_state == S_DONE) o_done = N_REQ'(1) << r_last;
  end

  // Operands are captured only in the grant cycle; later req_* changes are ignored.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_last       <= IDX_W'(N_REQ - 1);
      r_ev_x       <= '0;
      r_ev_a       <= '0;
      r_ev_b       <= '0;
      r_ev_c       <= '0;
      r_rsp_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt  <= N_REQ'(1) << w_win;
        r_last <= w_win;
        r_ev_x <= i_req_x[w_win*X_W +: X_W];
        r_ev_a <= i_req_a[w_win*C_W +: C_W];
        r_ev_b <= i_req_b[w_win*C_W +: C_W];
        r_ev_c <= i_req_c[w_win*C_W +: C_W];
      end else if (r_state == S_DONE) begin
        r_gnt <= '0;
      end
      if (w_capture)      r_rsp_result <= i_ev_result;
      else if (w_timeout) r_rsp_result <= '0;
    end
  end

`ifdef POLY_ARB_TIMEOUT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_rsp_err  <= 1'b0;
      r_ev_reset <= 1'b0;
    end else begin
      r_cnt      <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
      r_ev_reset <= w_timeout;
      if (w_capture)      r_rsp_err <= 1'b0;
      else if (w_timeout) r_rsp_err <= 1'b1;
    end
  end

  assign o_rsp_err  = r_rsp_err;
  assign o_ev_reset = r_ev_reset;
`else
  assign o_rsp_err  = 1'b0;
  assign o_ev_reset = 1'b0;
`endif

  assign o_gnt        = r_gnt;
  assign o_rsp_result = r_rsp_result;
  assign o_ev_x       = r_ev_x;
  assign o_ev_a       = r_ev_a;
  assign o_ev_b       = r_ev_b;
  assign o_ev_c       = r_ev_c;

endmodule

// File: doc/poly_arbiter.md
POLY_ARBITER -- requirements
Module: poly_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, 16, max cycles in WAIT before abort (used only with POLY_ARB_TIMEOUT_EN).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester request level; held with operands until own done pulse.
REQ-006 req_x  input  8*N_REQ  packed x operands; slice i belongs to requester i.
REQ-007 req_a, req_b, req_c  input  16*N_REQ each  packed coefficient operands.
REQ-008 gnt  output  N_REQ  one-hot grant, high from grant cycle through DONE.
REQ-009 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 rsp_result  output  16  result of last completed operation, held until next done.
REQ-011 rsp_err  output  1  qualifies done; 1 = operation aborted by timeout.
REQ-012 ev_enable  output  1  start strobe to the shared a*x^2+b*x+c evaluator.
REQ-013 ev_x (8), ev_a, ev_b, ev_c (16)  output  registered operands to evaluator.
REQ-014 ev_ready, ev_valid  input  1 each  evaluator idle / result-valid status.
REQ-015 ev_result  input  16  evaluator result, sampled when ev_valid=1.
REQ-016 ev_reset  output  1  evaluator recovery reset pulse.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: if any req bit=1 and ev_ready=1, select winner, set gnt, latch winner's operands into ev_* registers, go ISSUE; else stay.
REQ-019 Winner SHALL be the first set req bit searching upward (with wrap) from last_served+1.
REQ-020 last_served SHALL update to the winner index in the grant cycle.
REQ-021 ISSUE: ev_enable=1 for exactly this one cycle, go WAIT.
REQ-022 WAIT: on ev_valid=1 capture ev_result into rsp_result, clear rsp_err, go DONE.
REQ-023 DONE: done[winner]=1 one cycle, then clear gnt and go IDLE; earliest next grant is the cycle after DONE.
REQ-024 Operands SHALL be sampled only at grant; later changes on req_* have no effect on the running operation.
REQ-025 Requester dropping req mid-operation SHALL not abort it; done is still pulsed.
REQ-026 req still high after own done SHALL be treated as a new request subject to round-robin order.
REQ-027 Arithmetic is performed by the evaluator modulo 2^16; arbiter passes rsp_result unmodified.
REQ-028 ev_valid outside WAIT SHALL be ignored.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, gnt=0, done=0, ev_enable=0, ev_reset=0, rsp_result=0, rsp_err=0, ev_* operands=0, last_served=N_REQ-1.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-031 Macro POLY_ARB_TIMEOUT_EN defined: counter runs in WAIT; reaching TIMEOUT cycles without ev_valid SHALL set rsp_err=1, rsp_result=0, pulse ev_reset for one cycle, go DONE.
REQ-032 Macro undefined: no counter, WAIT holds indefinitely, ev_reset tied 0, rsp_err tied 0.

Structure
REQ-033 Shared package poly_pkg SHALL hold the state enum, operand widths (X_W=8, C_W=16) and default TIMEOUT.
REQ-034 Round-robin selection SHALL be a sub-module rr_picker (req, last_served -> winner index, any_valid), combinational.

Verification
REQ-035 Single req[0], x=3,a=2,b=5,c=7 -> ev_enable one cycle after grant, done[0] with rsp_result=0x0028, rsp_err=0.
REQ-036 req=4'b1111 held after reset -> service order 0,1,2,3,0; one gnt bit at a time.
REQ-037 x=255,a=2,b=0,c=0 -> rsp_result=0xFC02 (wrap modulo 2^16).
REQ-038 req[1] drops during WAIT -> done[1] still pulses; req_a changed after grant has no effect on result.
REQ-039 With POLY_ARB_TIMEOUT_EN, model never asserts ev_valid -> 16 cycles in WAIT, then ev_reset pulse, done with rsp_err=1, rsp_result=0.
REQ-040 reset asserted in WAIT -> gnt=0 same cycle, no done pulse; next req[2] after release granted before req[3].
